prio_arbiter_rr: RTL and testbench

- Parametrised, registered successor to the team's 4:2 priority encoder.
- Encodes N request lines into a binary index plus a one-hot grant.
- Mode 0: fixed priority, highest index wins. Mode 1: round-robin priority.
- Result is held in an output register with a valid/ready handshake, so it can feed pipelined consumers without extra staging.

---
 rtl/prio_arb_pkg.sv | 16 +
 rtl/prio_arbiter_rr_enc.sv | 25 ++
 rtl/prio_arbiter_rr.sv | 85 ++++++++
 tb/tb_prio_arbiter_rr.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/prio_arb_pkg.sv
// Shared constants and helpers for the
// registered priority / round-robin arbiter.
package prio_arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/prio_arbiter_rr_enc.sv
// Combinational highest-set-bit encoder
// used for both arbitration searches.
module prio_enc_core
  import prio_arb_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2_min1(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_arbiter_rr.sv
// N-way arbiter, fixed or round-robin,
// with a registered valid/ready result.
module prio_arbiter_rr
  import prio_arb_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2_min1(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_grant
);

  logic [W-1:0] ptr;
  logic [N-1:0] mask;
  logic [W-1:0] m_idx;
  logic         m_any;
  logic [W-1:0] u_idx;
  logic         u_any;
  logic [W-1:0] winner;
  logic         load;
  logic         free;

  // Masked search covers ptr down to 0 first.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (W'(i) <= ptr);
    end
  end

  prio_enc_core #(.N(N)) u_masked (
    .vec (req & mask),
    .idx (m_idx),
    .any (m_any)
  );

  prio_enc_core #(.N(N)) u_full (
    .vec (req),
    .idx (u_idx),
    .any (u_any)
  );

  always_comb begin
    winner = u_idx;
    if (mode == MODE_RR && m_any) begin
      winner = m_idx;
    end
  end

  assign free = !out_valid || out_ready;
  assign load = en && free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_grant <= '0;
      ptr       <= W'(N - 1);
    end else if (load) begin
      if (u_any) begin
        out_valid <= 1'b1;
        out_idx   <= winner;
        out_grant <= N'(1) << winner;
        if (mode == MODE_RR) begin
          ptr <= (winner == '0) ? W'(N - 1)
                                : winner - W'(1);
        end
      end else begin
        out_valid <= 1'b0;
        out_grant <= '0;
      end
    end else if (free) begin
      out_valid <= 1'b0;
      out_grant <= '0;
    end
  end

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Directed + random bench for prio_arbiter_rr
// with a queue-based scoreboard.
module tb_prio_arbiter_rr;

  typedef struct {
    logic       v;
    logic [1:0] idx;
    logic [3:0] g;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       en;
  logic       mode;
  logic       rdy;
  logic       out_valid;
  logic [1:0] out_idx;
  logic [3:0] out_grant;
  logic [0:0] req1;
  logic       v1;
  logic [0:0] idx1;
  logic [0:0] g1;

  int errors = 0;
  int checks = 0;

  exp_t sb[$];
  logic       mv;
  logic [1:0] midx;
  logic [3:0] mgrant;
  logic [1:0] mptr;

  prio_arbiter_rr #(.N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .en        (en),
    .mode      (mode),
    .out_ready (rdy),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_grant (out_grant)
  );

  prio_arbiter_rr #(.N(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .req       (req1),
    .en        (en),
    .mode      (mode),
    .out_ready (rdy),
    .out_valid (v1),
    .out_idx   (idx1),
    .out_grant (g1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mv     = 1'b0;
    midx   = 2'd0;
    mgrant = 4'd0;
    mptr   = 2'd3;
    sb.delete();
  endtask

  // Reference behaviour for one rising edge.
  task automatic model_step();
    int   w;
    exp_t e;
    w = -1;
    if (en && (!mv || rdy)) begin
      if (mode) begin
        for (int k = 0; k < 4; k++) begin
          int j;
          j = (int'(mptr) + 4 - k) % 4;
          if (w < 0 && req[j]) w = j;
        end
      end else begin
        for (int j = 0; j < 4; j++)
          if (req[j]) w = j;
      end
      if (w >= 0) begin
        mv     = 1'b1;
        midx   = 2'(w);
        mgrant = 4'd1 << w;
        if (mode)
          mptr = (w == 0) ? 2'd3 : 2'(w - 1);
      end else begin
        mv     = 1'b0;
        mgrant = 4'd0;
      end
    end else if (!mv || rdy) begin
      mv     = 1'b0;
      mgrant = 4'd0;
    end
    e.v   = mv;
    e.idx = midx;
    e.g   = mgrant;
    sb.push_back(e);
  endtask

  task automatic cyc(input string tag);
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, "_v"}, 32'(out_valid), 32'(e.v));
    chk({tag, "_i"}, 32'(out_idx), 32'(e.idx));
    chk({tag, "_g"}, 32'(out_grant), 32'(e.g));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  int seq_a[5] = '{3, 2, 1, 0, 3};
  int seq_b[4] = '{3, 0, 3, 0};

  initial begin
    rst  = 1'b1;
    req  = 4'd0;
    req1 = 1'b0;
    en   = 1'b0;
    mode = 1'b0;
    rdy  = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_v", 32'(out_valid), 0);
    chk("rst_i", 32'(out_idx), 0);
    chk("rst_g", 32'(out_grant), 0);
    chk("rst_p", 32'(dut.ptr), 3);
    rst = 1'b0;

    en  = 1'b1;
    req = 4'b0110;
    cyc("fix");
    chk("fix_idx", 32'(out_idx), 2);
    chk("fix_gnt", 32'(out_grant), 4'b0100);

    pulse_reset();
    mode = 1'b1;
    req  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cyc("rot");
      chk("rot_seq", 32'(out_idx), seq_a[i]);
    end

    pulse_reset();
    req = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      cyc("wrap");
      chk("wrap_seq", 32'(out_idx), seq_b[i]);
    end
    chk("wrap_ptr", 32'(dut.ptr), 3);

    req = 4'b0010;
    cyc("bp0");
    chk("bp0_idx", 32'(out_idx), 1);
    rdy = 1'b0;
    req = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      cyc("bp");
      chk("bp_idx", 32'(out_idx), 1);
      chk("bp_ptr", 32'(dut.ptr), 0);
    end
    rdy = 1'b1;
    cyc("bp_rel");
    chk("bp_rel_idx", 32'(out_idx), 3);

    en = 1'b0;
    cyc("en0");
    chk("en0_v", 32'(out_valid), 0);
    en  = 1'b1;
    req = 4'd0;
    cyc("empty");
    chk("empty_g", 32'(out_grant), 0);

    req = 4'b1111;
    cyc("pre_rst");
    chk("pre_rst_v", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("async_v", 32'(out_valid), 0);
    chk("async_g", 32'(out_grant), 0);
    #2;
    rst = 1'b0;
    model_reset();
    cyc("post_rst");
    chk("post_rst_idx", 32'(out_idx), 3);

    for (int i = 0; i < 40; i++) begin
      req  = 4'($urandom_range(0, 15));
      mode = 1'($urandom_range(0, 1));
      en   = ($urandom_range(0, 3) != 0);
      rdy  = ($urandom_range(0, 2) != 0);
      cyc("rnd");
    end

    en   = 1'b1;
    rdy  = 1'b1;
    req1 = 1'b1;
    cyc("n1");
    chk("n1_v", 32'(v1), 1);
    chk("n1_i", 32'(idx1), 0);
    chk("n1_g", 32'(g1), 1);
    req1 = 1'b0;
    cyc("n1e");
    chk("n1e_v", 32'(v1), 0);
    chk("n1e_g", 32'(g1), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
